iterative_multiplier: RTL

Parametrised multi-cycle multiply/multiply-accumulate unit. It is the next-generation replacement for the single-cycle multiplier feeding the processor writeback stage.
- Covers MUL, MLA, SMULL, SMLAL, UMULL and UMLAL at configurable operand width.
- Retires STEP_BITS multiplier bits per cycle.
- Uses a start/busy/done handshake so the execute stage can stall on it.
- Produces N and Z flags alongside the product.

---
 rtl/mult_pkg.sv | 13 +
 rtl/mult_step.sv | 17 +
 rtl/iterative_multiplier.sv | 97 +++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: type encodings, FSM states and step-count helper for iterative_multiplier
package mult_pkg;
  localparam logic [2:0] MUL_T   = 3'b000;
  localparam logic [2:0] MLA_T   = 3'b001;
  localparam logic [2:0] UMULL_T = 3'b100;
  localparam logic [2:0] UMLAL_T = 3'b101;
  localparam logic [2:0] SMULL_T = 3'b110;
  localparam logic [2:0] SMLAL_T = 3'b111;
  typedef enum logic [1:0] {IDLE, MUL, FIX, DONE} state_t;
  function automatic int step_count(int width, int step);
    return width / step;
  endfunction
endpackage

// File: rtl/mult_step.sv
// mult_step: adds STEP_BITS partial products into the accumulator and shifts the multiplier
module mult_step #(
  parameter int WIDTH = 32,
  parameter int STEP_BITS = 1
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [2*WIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]   mplier,
  output logic [2*WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0]   mplier_next
);
  always_comb begin
    acc_next = acc;
    for (int i = 0; i < STEP_BITS; i++) acc_next = acc_next + (mplier[i] ? mcand << i : '0);
    mplier_next = mplier >> STEP_BITS;
  end
endmodule

// File: rtl/iterative_multiplier.sv
// iterative_multiplier: multi-cycle MUL/MLA/UMULL/UMLAL/SMULL/SMLAL with start/busy/done handshake
// Define MULT_EARLY_TERM_EN to leave the MUL phase as soon as the remaining multiplier is zero.
module iterative_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP_BITS = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [2:0]         mul_type,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [WIDTH-1:0]   c,
  input  logic [WIDTH-1:0]   d,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               n_flag,
  output logic               z_flag
);
  localparam int N = step_count(WIDTH, STEP_BITS);
  localparam int CW = $clog2(N + 1);
  state_t state, state_nxt;
  logic [2:0] op;
  logic sign, accept, last, signed_in, long_op;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] c_q, d_q, mplier, mplier_nxt, a_mag, b_mag, lo;
  logic [2*WIDTH-1:0] acc, acc_nxt, mcand, prod, res_nxt;
  mult_step #(.WIDTH(WIDTH), .STEP_BITS(STEP_BITS)) u_step (
    .acc(acc),
    .mcand(mcand),
    .mplier(mplier),
    .acc_next(acc_nxt),
    .mplier_next(mplier_nxt)
  );
  always_comb begin
    signed_in = mul_type[2:1] == 2'b11;
    a_mag = signed_in && a[WIDTH-1] ? -a : a;
    b_mag = signed_in && b[WIDTH-1] ? -b : b;
    accept = start && (state == IDLE || state == DONE);
`ifdef MULT_EARLY_TERM_EN
    last = cnt == '0 || mplier_nxt == '0;
`else
    last = cnt == '0;
`endif
    state_nxt = accept ? MUL : state == MUL ? (last ? FIX : MUL) : state == FIX ? DONE : IDLE;
    busy = state == MUL || state == FIX;
    done = state == DONE;
    prod = sign ? -acc : acc;
    long_op = op[2];
    lo = prod[WIDTH-1:0] + (op == MLA_T ? c_q : '0);
    // unsupported encodings fall through to zero, which yields z=1, n=0
    res_nxt = op == MUL_T || op == MLA_T ? {{WIDTH{1'b0}}, lo} :
              op == UMULL_T || op == SMULL_T ? prod :
              op == UMLAL_T || op == SMLAL_T ? prod + {c_q, d_q} : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      op <= '0;
      sign <= 1'b0;
      cnt <= '0;
      c_q <= '0;
      d_q <= '0;
      mplier <= '0;
      acc <= '0;
      mcand <= '0;
      result <= '0;
      n_flag <= 1'b0;
      z_flag <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op <= mul_type;
        sign <= signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
        cnt <= CW'(N - 1);
        c_q <= c;
        d_q <= d;
        mplier <= b_mag;
        acc <= '0;
        mcand <= {{WIDTH{1'b0}}, a_mag};
      end else if (state == MUL) begin
        acc <= acc_nxt;
        mcand <= mcand << STEP_BITS;
        mplier <= mplier_nxt;
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        result <= res_nxt;
        n_flag <= long_op ? res_nxt[2*WIDTH-1] : res_nxt[WIDTH-1];
        z_flag <= long_op ? res_nxt == '0 : res_nxt[WIDTH-1:0] == '0;
      end
    end
  end
endmodule
